spi_master_core: RTL and testbench

//  Parametrised SPI master shift engine for the Zorro-side SD/SPI controllers.

---
 rtl/spi_master_core.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_master_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// spi_master_core: parametrised SPI master shift engine.
// DW-bit word shifter with runtime CPOL/CPHA, bit order and SCLK divider,
// NCS active-low selects and an optional CRC16-CCITT accumulator.
// Optional feature macro: SPI_CRC16_EN (undefined: crc_out is tied to zero).
module spi_master_core #(
  parameter int DW   = 8,
  parameter int NCS  = 4,
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_wr,
  input  logic            cfg_cpol,
  input  logic            cfg_cpha,
  input  logic            cfg_lsb,
  input  logic [DIVW-1:0] cfg_div,
  input  logic            cs_wr,
  input  logic [NCS-1:0]  cs_sel,
  input  logic            start,
  input  logic [DW-1:0]   tx_data,
  output logic [DW-1:0]   rx_data,
  output logic            busy,
  output logic            done,
  input  logic            crc_clr,
  input  logic            crc_src,
  output logic [15:0]     crc_out,
  input  logic            miso,
  output logic            mosi,
  output logic            sclk,
  output logic [NCS-1:0]  cs_n
);

  localparam int EW = $clog2(2 * DW) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic [NCS-1:0]    cs_q, cs_d;
  logic [DIVW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [DW-1:0]     rxd_q, rxd_d;
  logic [DW-1:0]     tx_q, tx_d;
  logic [DW-1:0]     rx_q, rx_d;
  logic              sample_ev;
  logic              lead, samp, last;

  // Bit currently at the output end of a word for the given order.
  function automatic logic out_bit(input logic [DW-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DW-1];
  endfunction

  // Drop the output-end bit.
  function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DW-1:1]} : {w[DW-2:0], 1'b0};
  endfunction

  // Insert a received bit so the word assembles in transmit order.
  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] w, input logic lsb,
                                             input logic b);
    return lsb ? {b, w[DW-1:1]} : {w[DW-2:0], b};
  endfunction

  // Next-state, configuration capture and shift datapath.
  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    div_d     = div_q;
    cs_d      = cs_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    rxd_d     = rxd_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sample_ev = 1'b0;
    lead      = ~edge_q[0];
    samp      = lead ^ cpha_q;
    last      = (edge_q == LAST_EDGE);

    // Config and select writes apply before a same-cycle start.
    if (state_q == S_IDLE && cfg_wr) begin
      cpol_d = cfg_cpol;
      cpha_d = cfg_cpha;
      lsb_d  = cfg_lsb;
      div_d  = cfg_div;
    end
    if (state_q == S_IDLE && cs_wr) begin
      cs_d = cs_sel;
    end

    case (state_q)
      S_IDLE: begin
        sclk_d = cpol_d;
        mosi_d = 1'b1;
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = div_d;
          edge_d  = '0;
          if (!cpha_d) begin
            mosi_d = out_bit(tx_data, lsb_d);
            tx_d   = shift_out(tx_data, lsb_d);
          end else begin
            tx_d   = tx_data;
          end
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d  = div_q;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EW'(1);
          if (samp) begin
            sample_ev = 1'b1;
            rx_d      = shift_in(rx_q, lsb_q, miso);
          end else if (!last) begin
            mosi_d = out_bit(tx_q, lsb_q);
            tx_d   = shift_out(tx_q, lsb_q);
          end
          if (last) begin
            state_d = S_DONE;
            mosi_d  = 1'b1;
            rxd_d   = samp ? shift_in(rx_q, lsb_q, miso) : rx_q;
          end
        end else begin
          cnt_d = cnt_q - DIVW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        mosi_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      div_q   <= '0;
      cs_q    <= '0;
      cnt_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      rxd_q   <= '0;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      div_q   <= div_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      rxd_q   <= rxd_d;
    end
  end

  // Shift registers hold pure data and need no reset.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = ~cs_q;
  assign rx_data = rxd_q;

`ifdef SPI_CRC16_EN
  logic [15:0] crc_q, crc_d;
  logic        src_q, src_d;

  // One MSB-first CRC16-CCITT (poly 0x1021) step for a single bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // CRC update on every sample edge; the MOSI bit on the wire at that edge
  // is the bit being shifted out. Clear wins over update.
  always_comb begin
    crc_d = crc_q;
    src_d = src_q;
    if (state_q == S_IDLE && start) begin
      src_d = crc_src;
    end
    if (sample_ev) begin
      crc_d = crc16_step(crc_q, src_q ? miso : mosi_q);
    end
    if (crc_clr) begin
      crc_d = 16'h0000;
    end
  end

  // CRC accumulator and source select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 16'h0000;
      src_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      src_q <= src_d;
    end
  end

  assign crc_out = crc_q;
`else
  logic crc_unused;
  assign crc_unused = ^{crc_clr, crc_src, sample_ev};
  assign crc_out    = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_master_core.sv
// tb_spi_master_core: directed bench with an arithmetic timing/data model of
// the SPI master, a per-cycle compare process and literal pin-down checks.
module tb_spi_master_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0, cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
  logic [7:0]  cfg_div = 8'd0;
  logic        cs_wr = 1'b0;
  logic [3:0]  cs_sel = 4'd0;
  logic        start = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic [7:0]  rx_data;
  logic        busy, done;
  logic        crc_clr = 1'b0, crc_src = 1'b0;
  logic [15:0] crc_out;
  logic        miso, mosi, sclk;
  logic [3:0]  cs_n;

  int miso_mode = 2;
  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

  spi_master_core #(.DW(8), .NCS(4), .DIVW(8)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb(cfg_lsb), .cfg_div(cfg_div), .cs_wr(cs_wr), .cs_sel(cs_sel),
    .start(start), .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .crc_clr(crc_clr), .crc_src(crc_src), .crc_out(crc_out), .miso(miso),
    .mosi(mosi), .sclk(sclk), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  bit         m_cpol = 0, m_cpha = 0, m_lsb = 0;
  int         m_div  = 0;
  logic [3:0] m_cs   = 4'd0;
  logic [7:0] m_rx   = 8'd0;
  logic [7:0] m_tx   = 8'd0;
  logic [7:0] m_exp_rx = 8'd0;
  logic [15:0] m_crc = 16'd0;
  bit         act = 0;
  int         d = 0;
  int         busy_cnt = 0, rise_cnt = 0, done_cnt = 0;
  logic       prev_sclk = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic mbit(input logic [7:0] w, input int i, input bit lsb);
    return lsb ? w[i] : w[7-i];
  endfunction

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    logic exp_busy, exp_done, exp_sclk, exp_mosi;
    int   len, es;
    if (!rst) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_sclk = m_cpol;
      exp_mosi = 1'b1;
      if (act) begin
        d++;
        len = 16 * (m_div + 1);
        if (d <= len) begin
          exp_busy = 1'b1;
          es = (d - 1) / (m_div + 1);
          exp_sclk = m_cpol ^ (es % 2 == 1);
          if (!m_cpha) exp_mosi = mbit(m_tx, es / 2, m_lsb);
          else exp_mosi = (es == 0) ? 1'b1 : mbit(m_tx, (es - 1) / 2, m_lsb);
        end else begin
          exp_done = 1'b1;
          m_rx = m_exp_rx;
          act = 0;
        end
        if (busy) busy_cnt++;
        if (sclk && !prev_sclk) rise_cnt++;
      end
      if (done) done_cnt++;
      chk("cycle{busy,done,sclk,mosi,cs_n,rx}",
          {16'd0, busy, done, sclk, mosi, cs_n, rx_data},
          {16'd0, exp_busy, exp_done, exp_sclk, exp_mosi, ~m_cs, m_rx});
      prev_sclk = sclk;
    end
  end

  task automatic set_cfg(input bit cpol, input bit cpha, input bit lsb, input int div);
    @(negedge clk);
    cfg_wr = 1; cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb = lsb; cfg_div = div[7:0];
    @(posedge clk);
    m_cpol = cpol; m_cpha = cpha; m_lsb = lsb; m_div = div;
    @(negedge clk);
    cfg_wr = 0;
  endtask

  task automatic set_cs(input logic [3:0] v);
    @(negedge clk);
    cs_wr = 1; cs_sel = v;
    @(posedge clk);
    m_cs = v;
    @(negedge clk);
    cs_wr = 0;
  endtask

  task automatic clr_crc();
    @(negedge clk);
    crc_clr = 1;
    @(posedge clk);
    m_crc = 16'd0;
    @(negedge clk);
    crc_clr = 0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (act && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (act) begin
      chk("transfer_timeout", 32'd1, 32'd0);
      act = 0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int mm, input bit src, input bit wcfg,
                      input bit cpol, input bit cpha, input bit lsb, input int div,
                      input bit wait_end);
    logic b;
    @(negedge clk);
    miso_mode = mm;
    start = 1; tx_data = tx; crc_src = src;
    if (wcfg) begin
      cfg_wr = 1; cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb = lsb; cfg_div = div[7:0];
    end
    @(posedge clk);
    if (wcfg) begin
      m_cpol = cpol; m_cpha = cpha; m_lsb = lsb; m_div = div;
    end
    m_tx = tx;
    m_exp_rx = (mm == 0) ? tx : ((mm == 1) ? 8'hFF : 8'h00);
    for (int i = 0; i < 8; i++) begin
      b = src ? mbit(m_exp_rx, i, m_lsb) : mbit(tx, i, m_lsb);
      m_crc = crc_bit(m_crc, b);
    end
    busy_cnt = 0; rise_cnt = 0;
    d = 0; act = 1;
    @(negedge clk);
    start = 0; cfg_wr = 0;
    if (wait_end) wait_idle(6000);
  endtask

  int dc0;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 1);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_rx", rx_data, 0);
    chk("rst_crc", crc_out, 0);

    set_cs(4'b0010);

    // Mode 0, div 0, loopback
    set_cfg(0, 0, 0, 0);
    xfer(8'hA5, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t1_rx", rx_data, 8'hA5);
    chk("t1_busy_cycles", busy_cnt, 16);
    chk("t1_rising_edges", rise_cnt, 8);

    // Mode 3, LSB first, div 3, cfg written in the start cycle
    xfer(8'h3C, 1, 0, 1, 1, 1, 1, 3, 1);
    chk("t2_rx", rx_data, 8'hFF);
    chk("t2_busy_cycles", busy_cnt, 64);
    @(negedge clk);
    chk("t2_sclk_idle", sclk, 1);

    // Mode 1, div 2, loopback
    set_cfg(0, 1, 0, 2);
    xfer(8'h96, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t3_rx", rx_data, 8'h96);

    // Mode 2, LSB first, div 1, loopback
    set_cfg(1, 0, 1, 1);
    xfer(8'h01, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_rx", rx_data, 8'h01);

    // Maximum divider
    set_cfg(0, 0, 0, 255);
    xfer(8'h5A, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t5_rx", rx_data, 8'h5A);
    chk("t5_busy_cycles", busy_cnt, 4096);

    // Writes during busy are ignored
    set_cfg(0, 0, 0, 1);
    dc0 = done_cnt;
    xfer(8'hC3, 2, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    start = 1; tx_data = 8'hFF; cs_wr = 1; cs_sel = 4'h1;
    cfg_wr = 1; cfg_cpol = 1; cfg_cpha = 1; cfg_lsb = 1; cfg_div = 8'd7;
    @(negedge clk);
    start = 0; cs_wr = 0; cfg_wr = 0;
    wait_idle(6000);
    repeat (3) @(negedge clk);
    chk("t6_cs_n_kept", cs_n, 4'b1101);
    chk("t6_sclk_cpol_kept", sclk, 0);
    chk("t6_one_done", done_cnt - dc0, 1);
    chk("t6_rx", rx_data, 8'h00);

`ifdef SPI_CRC16_EN
    set_cfg(0, 0, 0, 0);
    clr_crc();
    begin
      logic [7:0] msg [9];
      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      for (int i = 0; i < 9; i++) xfer(msg[i], 2, 0, 0, 0, 0, 0, 0, 1);
    end
    chk("crc_check_string", crc_out, 16'h31C3);
    chk("crc_model_a", crc_out, m_crc);
    clr_crc();
    for (int i = 0; i < 512; i++) xfer(8'h00, 1, 1, 0, 0, 0, 0, 0, 1);
    chk("crc_512_ff", crc_out, 16'h7FA1);
    chk("crc_model_b", crc_out, m_crc);
`else
    clr_crc();
    xfer(8'h31, 1, 1, 0, 0, 0, 0, 0, 1);
    chk("crc_tied_zero", crc_out, 16'h0000);
`endif

    // Reset in the middle of a transfer
    set_cfg(1, 0, 0, 2);
    xfer(8'h81, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (7) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_mosi", mosi, 1);
    chk("mid_rst_cs_n", cs_n, 4'hF);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    act = 0;
    m_cpol = 0; m_cpha = 0; m_lsb = 0; m_div = 0; m_cs = 4'd0; m_rx = 8'd0;
    @(negedge clk);
    rst = 0;
    dc0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - dc0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
